// File: rtl/bus_arbiter_if.sv
// Two-master serial bus arbitration signals: requests/valid from the masters,
// grants and status from the arbiter.
interface bus_arbiter_if;
  logic mreq1;
  logic mreq2;
  logic mvalid;
  logic mgrant1;
  logic mgrant2;
  logic msel;
  logic bus_busy;
  logic timeout_err;

  modport master (
    output mreq1, mreq2, mvalid,
    input  mgrant1, mgrant2, msel, bus_busy, timeout_err
  );

  modport slave (
    input  mreq1, mreq2, mvalid,
    output mgrant1, mgrant2, msel, bus_busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for two bus masters with a mandatory dead cycle between owners.
// Optional idle-bus grant revocation is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rstn,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGnt1, StGnt2, StRel} state_e;

  state_e r_state;
  state_e w_state_d;
  logic   r_last;  // master served last: 0 = master 1, 1 = master 2
  logic   w_req1;
  logic   w_req2;
  logic   w_timeout;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_idle_cnt;
  logic       r_mask1;
  logic       r_mask2;
  logic       w_cnt_hit;

  assign w_cnt_hit = (r_idle_cnt == 8'(TIMEOUT - 1)) && !bus.mvalid;
  // A master that has already released its request leaves normally, not by timeout.
  assign w_timeout = w_cnt_hit && ((r_state == StGnt1 && bus.mreq1) ||
                                   (r_state == StGnt2 && bus.mreq2));
  assign w_req1    = bus.mreq1 & ~r_mask1;
  assign w_req2    = bus.mreq2 & ~r_mask2;
`else
  logic [8:0] w_unused_cfg;

  assign w_unused_cfg = {8'(TIMEOUT), bus.mvalid};
  assign w_timeout    = 1'b0;
  assign w_req1       = bus.mreq1;
  assign w_req2       = bus.mreq2;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StGnt1: if (!bus.mreq1 || w_timeout) w_state_d = StRel;
      StGnt2: if (!bus.mreq2 || w_timeout) w_state_d = StRel;
      default: begin
        // The REL cycle is the dead cycle itself, so it arbitrates like IDLE.
        if (w_req1 && w_req2) w_state_d = r_last ? StGnt1 : StGnt2;
        else if (w_req1)      w_state_d = StGnt1;
        else if (w_req2)      w_state_d = StGnt2;
        else                  w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state         <= StIdle;
      r_last          <= 1'b0;
      bus.mgrant1     <= 1'b0;
      bus.mgrant2     <= 1'b0;
      bus.msel        <= 1'b0;
      bus.bus_busy    <= 1'b0;
      bus.timeout_err <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_idle_cnt      <= 8'd0;
      r_mask1         <= 1'b0;
      r_mask2         <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_d;
      bus.mgrant1     <= (w_state_d == StGnt1);
      bus.mgrant2     <= (w_state_d == StGnt2);
      bus.bus_busy    <= (w_state_d == StGnt1) || (w_state_d == StGnt2);
      bus.timeout_err <= w_timeout;
      if (w_state_d == StGnt1) bus.msel <= 1'b0;
      else if (w_state_d == StGnt2) bus.msel <= 1'b1;
      if (w_state_d == StGnt1 && r_state != StGnt1) r_last <= 1'b0;
      else if (w_state_d == StGnt2 && r_state != StGnt2) r_last <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      if ((w_state_d == StGnt1 || w_state_d == StGnt2) && w_state_d == r_state && !bus.mvalid) begin
        r_idle_cnt <= r_idle_cnt + 8'd1;
      end else begin
        r_idle_cnt <= 8'd0;
      end
      // Mask holds until the timed-out master drops its request for a cycle.
      if (!bus.mreq1) r_mask1 <= 1'b0;
      else if (w_timeout && r_state == StGnt1) r_mask1 <= 1'b1;
      if (!bus.mreq2) r_mask2 <= 1'b0;
      else if (w_timeout && r_state == StGnt2) r_mask2 <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run
// against a behavioural ownership model.
module tb_bus_arbiter;
  localparam int unsigned TIMEOUT = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  // {mgrant1, mgrant2, msel, bus_busy, timeout_err}
  function automatic logic [4:0] out_vec();
    return {bif.mgrant1, bif.mgrant2, bif.msel, bif.bus_busy, bif.timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    bif.mreq1  = 1'b0;
    bif.mreq2  = 1'b0;
    bif.mvalid = 1'b1;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    bif.mreq1  = 1'b1;
    bif.mreq2  = 1'b1;
    bif.mvalid = 1'b0;
    tick();
    tick();
    checks++;
    if (out_vec() !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", out_vec(), 5'b00000);
    end
    do_reset();
  endtask

  task automatic test_single_grant();
    do_reset();
    bif.mreq1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (out_vec() !== 5'b10010) begin
        failures++;
        $display("FAIL single_grant cyc=%0d got=%b want=%b", i, out_vec(), 5'b10010);
      end
      if (i == 10) bif.mreq1 = 1'b0;
    end
    for (int i = 11; i <= 12; i++) begin
      tick();
      checks++;
      if (out_vec() !== 5'b00000) begin
        failures++;
        $display("FAIL single_release cyc=%0d got=%b want=%b", i, out_vec(), 5'b00000);
      end
    end
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    bif.mreq1 = 1'b1;
    bif.mreq2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (out_vec() !== 5'b01110) begin
        failures++;
        $display("FAIL first_tie cyc=%0d got=%b want=%b", i, out_vec(), 5'b01110);
      end
    end
    bif.mreq2 = 1'b0;
    tick();
    checks++;
    if (out_vec() !== 5'b00100) begin
      failures++;
      $display("FAIL tie_dead_cycle got=%b want=%b", out_vec(), 5'b00100);
    end
    tick();
    checks++;
    if (out_vec() !== 5'b10010) begin
      failures++;
      $display("FAIL tie_second_grant got=%b want=%b", out_vec(), 5'b10010);
    end
    bif.mreq1 = 1'b0;
    tick();
    bif.mreq1 = 1'b1;
    bif.mreq2 = 1'b1;
    tick();
    checks++;
    if (out_vec() !== 5'b01110) begin
      failures++;
      $display("FAIL second_tie got=%b want=%b", out_vec(), 5'b01110);
    end
    bif.mreq1 = 1'b0;
    bif.mreq2 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_no_preempt();
    do_reset();
    bif.mreq1 = 1'b1;
    tick();
    bif.mreq2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_vec() !== 5'b10010) begin
        failures++;
        $display("FAIL no_preempt cyc=%0d got=%b want=%b", i, out_vec(), 5'b10010);
      end
      tick();
    end
    bif.mreq1 = 1'b0;
    tick();
    checks++;
    if (out_vec() !== 5'b00000) begin
      failures++;
      $display("FAIL preempt_dead got=%b want=%b", out_vec(), 5'b00000);
    end
    tick();
    checks++;
    if (out_vec() !== 5'b01110) begin
      failures++;
      $display("FAIL preempt_handover got=%b want=%b", out_vec(), 5'b01110);
    end
    bif.mreq2 = 1'b0;
    tick();
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bif.mvalid = 1'b0;
    bif.mreq1  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (out_vec() !== 5'b10010) begin
        failures++;
        $display("FAIL timeout_hold cyc=%0d got=%b want=%b", i, out_vec(), 5'b10010);
      end
    end
    tick();
    checks++;
    if (out_vec() !== 5'b00001) begin
      failures++;
      $display("FAIL timeout_pulse got=%b want=%b", out_vec(), 5'b00001);
    end
    bif.mvalid = 1'b1;
    bif.mreq2  = 1'b1;
    tick();
    checks++;
    if (out_vec() !== 5'b01110) begin
      failures++;
      $display("FAIL timeout_other_master got=%b want=%b", out_vec(), 5'b01110);
    end
    bif.mreq2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_vec() !== 5'b00100) begin
        failures++;
        $display("FAIL timeout_masked cyc=%0d got=%b want=%b", i, out_vec(), 5'b00100);
      end
    end
    bif.mreq1 = 1'b0;
    tick();
    bif.mreq1 = 1'b1;
    tick();
    checks++;
    if (out_vec() !== 5'b10010) begin
      failures++;
      $display("FAIL timeout_regrant got=%b want=%b", out_vec(), 5'b10010);
    end
    bif.mreq1 = 1'b0;
    tick();
    tick();
  endtask
`else
  task automatic test_hold();
    do_reset();
    bif.mvalid = 1'b0;
    bif.mreq1  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (out_vec() !== 5'b10010) begin
        failures++;
        $display("FAIL hold_no_timeout cyc=%0d got=%b want=%b", i, out_vec(), 5'b10010);
      end
    end
    bif.mreq1  = 1'b0;
    bif.mvalid = 1'b1;
    tick();
    tick();
  endtask
`endif

  task automatic test_reset_mid_grant();
    do_reset();
    bif.mreq2 = 1'b1;
    tick();
    checks++;
    if (out_vec() !== 5'b01110) begin
      failures++;
      $display("FAIL midrst_pre got=%b want=%b", out_vec(), 5'b01110);
    end
    tick();
    rstn = 1'b0;
    tick();
    checks++;
    if (out_vec() !== 5'b00000) begin
      failures++;
      $display("FAIL midrst_revoke got=%b want=%b", out_vec(), 5'b00000);
    end
    rstn      = 1'b1;
    bif.mreq2 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int   m_owner = 0;  // 0 = nobody, 1/2 = master holding the bus
    int   m_last  = 1;
    int   m_idle  = 0;
    bit   m_mask1 = 1'b0;
    bit   m_mask2 = 1'b0;
    bit   m_msel  = 1'b0;
    bit   m_terr;
    bit   e1, e2;
    int   pick;
    int   fail0;
    logic [4:0] exp_v;
    logic [4:0] prev_v;
    do_reset();
    fail0  = failures;
    prev_v = out_vec();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(7) == 0) bif.mreq1 = ~bif.mreq1;
      if ($urandom_range(7) == 0) bif.mreq2 = ~bif.mreq2;
      bif.mvalid = 1'($urandom_range(1));
      m_terr = 1'b0;
      if (m_owner == 1) begin
        if (!bif.mreq1) m_owner = 0;
        else if (ToEn && !bif.mvalid && m_idle == int'(TIMEOUT) - 1) begin
          m_owner = 0; m_terr = 1'b1; m_mask1 = 1'b1;
        end else m_idle = bif.mvalid ? 0 : m_idle + 1;
      end else if (m_owner == 2) begin
        if (!bif.mreq2) m_owner = 0;
        else if (ToEn && !bif.mvalid && m_idle == int'(TIMEOUT) - 1) begin
          m_owner = 0; m_terr = 1'b1; m_mask2 = 1'b1;
        end else m_idle = bif.mvalid ? 0 : m_idle + 1;
      end else begin
        e1 = bif.mreq1 && !m_mask1;
        e2 = bif.mreq2 && !m_mask2;
        if (e1 && e2) pick = (m_last == 1) ? 2 : 1;
        else if (e1)  pick = 1;
        else if (e2)  pick = 2;
        else          pick = 0;
        if (pick != 0) begin
          m_owner = pick; m_last = pick; m_idle = 0; m_msel = (pick == 2);
        end
      end
      if (!bif.mreq1) m_mask1 = 1'b0;
      if (!bif.mreq2) m_mask2 = 1'b0;
      exp_v = {m_owner == 1, m_owner == 2, m_msel, m_owner != 0, m_terr};
      tick();
      checks++;
      if (out_vec() !== exp_v) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%b want=%b", c, out_vec(), exp_v);
      end
      checks++;
      if (bif.mgrant1 && bif.mgrant2) begin
        failures++;
        $display("FAIL random_overlap cyc=%0d got=%b want=not 11", c, {bif.mgrant1, bif.mgrant2});
      end
      checks++;
      if ((prev_v[4] && bif.mgrant2) || (prev_v[3] && bif.mgrant1)) begin
        failures++;
        $display("FAIL random_adjacent cyc=%0d prev=%b now=%b", c, prev_v[4:3],
                 {bif.mgrant1, bif.mgrant2});
      end
      checks++;
      if (bif.bus_busy !== (bif.mgrant1 | bif.mgrant2)) begin
        failures++;
        $display("FAIL random_busy cyc=%0d got=%b want=%b", c, bif.bus_busy,
                 bif.mgrant1 | bif.mgrant2);
      end
      prev_v = out_vec();
      if (failures != fail0) break;
    end
    bif.mreq1 = 1'b0;
    bif.mreq2 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bif.mreq1  = 1'b0;
    bif.mreq2  = 1'b0;
    bif.mvalid = 1'b1;
    test_reset();
    test_single_grant();
    test_tie_round_robin();
    test_no_preempt();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
